serial_word_rx: RTL and testbench
=================================

# serial_word_rx

Serial receiver feeding the top-level datapath: deserializes an asynchronous UART-style line (8N1 framing, LSB first) sampled on `clk`, pairs consecutive bytes into one `2*width_byte`-bit word and presents it on a valid/ready interface. It sits directly upstream of the top module's `i_a` word input and `i_rx_0` line, and flags framing and overrun errors.

## Interface
- `width_byte`, 8, bits per serial character; output word is `2*width_byte` bits.
- `clks_per_bit`, 16, `clk` cycles per serial bit; must be ≥4 and even.
- `clk`  input  1  single system clock, rising edge.
- `rst`  input  1  reset; asynchronous assert, active-low. All state clears while `rst`=0.
- `i_rx`  input  1  asynchronous serial line, idle high.
- `o_word`  output  `2*width_byte`  assembled word; first received byte in `[width_byte-1:0]`, second in upper half.
- `o_valid`  output  1  `o_word` holds an unconsumed word.
- `i_ready`  input  1  consumer accepts `o_word` when `o_valid && i_ready` on a rising edge.
- `o_frame_err`  output  1  one-cycle pulse: stop bit sampled low.
- `o_overrun`  output  1  one-cycle pulse: completed word dropped because `o_valid` was still high.

## Operation
- `i_rx` passes a 2-flop synchronizer; all logic uses the synchronized `rx_s`.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on `rx_s`=0 load bit counter with `clks_per_bit/2 - 1`, go START.
  - START: on counter expiry, if `rx_s`=0 reload `clks_per_bit-1`, clear bit index, go DATA; if `rx_s`=1 (glitch) return IDLE, no error.
  - DATA: on each expiry shift `rx_s` into the byte shift register (LSB first), increment bit index; after bit `width_byte-1` go STOP.
  - STOP: on expiry, if `rx_s`=1 the byte is good; if 0, pulse `o_frame_err`, discard the byte and any pending half-word. Go IDLE either way.
- Word assembly: a `half` flag. Good byte with `half`=0 → store in low-byte register, set `half`. Good byte with `half`=1 → form word, clear `half`, attempt load.
- Load: if `o_valid`=0, or `o_valid && i_ready` in the same cycle, load `o_word` and set `o_valid`. Otherwise pulse `o_overrun`, keep the old word and drop the new one.
- `o_valid` clears on accept when no load coincides.
- Bit counter width `$clog2(clks_per_bit)`; bit index width `$clog2(width_byte+1)`; no other arithmetic.

## Timing
- Reset values: `o_word`=0, `o_valid`=0, `o_frame_err`=0, `o_overrun`=0, FSM=IDLE, `half`=0, synchronizer flops=1.
- `rx_s` lags `i_rx` by 2 cycles.
- Each data bit is sampled at its nominal centre: `clks_per_bit/2 + k*clks_per_bit` cycles after the synchronized falling edge, for k=1..`width_byte`.
- `o_valid` rises on the rising edge after the stop-bit sample of the second byte.
- Error pulses occur on the same edge the word would have loaded.
- A new start edge is accepted on the cycle after STOP exits.
- Reset mid-frame: partial byte, `half`, and any held word are lost. Behaviour after release is identical to power-up.

## Structure
- `serial_word_rx_pkg`: FSM state enum (`IDLE`, `START`, `DATA`, `STOP`) and the 2-bit state typedef.
- Sub-module `sync_2ff`: 1-bit two-flop synchronizer with async active-low reset value parameter (1 here).
- Counters, FSM and output register live in `serial_word_rx`.

## Test plan
All scenarios use `width_byte`=8 and `clks_per_bit`=4.
- Reset mid-frame: send 0x3C, then pull `rst` low during its bit 3 and release → all outputs 0. A following 0xAA, 0xBB pair yields `o_word`=0xBBAA.
- Send 0x34 then 0x12 with `i_ready`=1 → `o_valid` high for exactly 1 cycle, `o_word`=0x1234, no error pulses.
- 0.5-bit low glitch on an idle line, then 0x01, 0x80 → no `o_frame_err`, `o_word`=0x8001.
- 0x55 with its stop bit forced low, then 0x11, 0x22 → one `o_frame_err` pulse; `o_word`=0x2211 (half-word discarded).
- Backpressure: `i_ready`=0, send words 0xA1B2 then 0xC3D4 → `o_word` stays 0xA1B2, one `o_overrun` pulse; after `i_ready`=1, `o_valid` drops.
- Accept and load in the same cycle: raise `i_ready` exactly on the cycle the second word completes → `o_word` becomes the new word, `o_valid` stays 1, no overrun.

Source files
------------

// File: rtl/serial_word_rx_pkg.sv
// serial_word_rx_pkg: receiver FSM state encoding shared by the serial word receiver
package serial_word_rx_pkg;
   typedef logic [1:0] state_bits_t;
   typedef enum state_bits_t {IDLE, START, DATA, STOP} state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous bit with a selectable reset value
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic [1:0] s_q, s_d;
   // shift the raw input through two stages
   always_comb s_d = {s_q[0], d};
   // both stages take the reset value while rst is low
   always_ff @(posedge clk or negedge rst)
      if (!rst) s_q <= {2{RST_VAL}};
      else      s_q <= s_d;
   assign q = s_q[1];
endmodule

// File: rtl/serial_word_rx.sv
// serial_word_rx: 8N1 serial receiver pairing bytes into words on a valid/ready output
module serial_word_rx
   import serial_word_rx_pkg::*;
#(
   parameter int width_byte   = 8,
   parameter int clks_per_bit = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_rx,
   output logic [2*width_byte-1:0] o_word,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic                    o_frame_err,
   output logic                    o_overrun
);
   localparam int CW = $clog2(clks_per_bit);
   localparam int IW = $clog2(width_byte + 1);
   localparam logic [CW-1:0] HALF_LD  = CW'(clks_per_bit / 2 - 1);
   localparam logic [CW-1:0] BIT_LD   = CW'(clks_per_bit - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(width_byte - 1);

   logic                    rx_s;
   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [width_byte-1:0]   sh_q, sh_d, lo_q, lo_d;
   logic                    half_q, half_d;
   logic [2*width_byte-1:0] word_q, word_d;
   logic                    valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
   logic                    expire, byte_ok;

   sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(i_rx), .q(rx_s));

   // bit timing, framing and word assembly; the counter free-runs down to zero and holds
   always_comb begin
      state_d = state_q;
      expire  = cnt_q == '0;
      cnt_d   = expire ? cnt_q : cnt_q - 1'b1;
      idx_d   = idx_q;
      sh_d    = sh_q;
      lo_d    = lo_q;
      half_d  = half_q;
      word_d  = word_q;
      valid_d = valid_q && !i_ready;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
      byte_ok = 1'b0;
      case (state_q)
         IDLE:
            if (!rx_s) begin
               cnt_d   = HALF_LD;
               state_d = START;
            end
         START:
            if (expire) begin
               cnt_d   = BIT_LD;
               idx_d   = '0;
               state_d = rx_s ? IDLE : DATA;
            end
         DATA:
            if (expire) begin
               sh_d    = {rx_s, sh_q[width_byte-1:1]};
               idx_d   = idx_q + 1'b1;
               cnt_d   = BIT_LD;
               state_d = (idx_q == LAST_IDX) ? STOP : DATA;
            end
         STOP:
            if (expire) begin
               state_d = IDLE;
               byte_ok = rx_s;
               ferr_d  = !rx_s;
               half_d  = rx_s && half_q;
            end
         default: state_d = IDLE;
      endcase
      if (byte_ok && !half_q) begin
         lo_d   = sh_q;
         half_d = 1'b1;
      end else if (byte_ok) begin
         half_d = 1'b0;
         if (!valid_q || i_ready) begin
            word_d  = {sh_q, lo_q};
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   // all receiver state clears asynchronously while rst is low
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         sh_q    <= '0;
         lo_q    <= '0;
         half_q  <= 1'b0;
         word_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
         lo_q    <= lo_d;
         half_q  <= half_d;
         word_q  <= word_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end

   assign o_word      = word_q;
   assign o_valid     = valid_q;
   assign o_frame_err = ferr_q;
   assign o_overrun   = ovr_q;
endmodule

// File: tb/tb_serial_word_rx.sv
// tb_serial_word_rx: directed and random 8N1 frames checked against a byte-level word model
module tb_serial_word_rx;
   localparam int WB  = 8;
   localparam int CPB = 4;

   logic            clk = 1'b0, rst = 1'b0, i_rx = 1'b1, i_ready = 1'b0;
   logic [2*WB-1:0] o_word;
   logic            o_valid, o_frame_err, o_overrun;
   int              vectors = 0, miscompares = 0;
   int              vld_cnt = 0, fe_cnt = 0, ov_cnt = 0;
   logic [2*WB-1:0] acc[$];

   serial_word_rx #(.width_byte(WB), .clks_per_bit(CPB)) dut (
      .clk(clk), .rst(rst), .i_rx(i_rx), .o_word(o_word), .o_valid(o_valid),
      .i_ready(i_ready), .o_frame_err(o_frame_err), .o_overrun(o_overrun));

   always #5 clk = ~clk;

   // observe between edges: pulses, valid cycles and words the consumer takes on the next edge
   always @(negedge clk) begin
      if (o_valid) vld_cnt++;
      if (o_frame_err) fe_cnt++;
      if (o_overrun) ov_cnt++;
      if (o_valid && i_ready) acc.push_back(o_word);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [WB-1:0] b, input logic stop = 1'b1, input int nbits = WB + 2);
      logic [WB+1:0] fr;
      fr = {stop, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         i_rx = fr[i];
         cyc(CPB);
      end
      i_rx = 1'b1;
   endtask

   task automatic send_word(input logic [2*WB-1:0] w);
      send_byte(w[WB-1:0]);
      cyc(2);
      send_byte(w[2*WB-1:WB]);
   endtask

   function automatic logic [2*WB-1:0] acc_at(input int i);
      return (i < acc.size()) ? acc[i] : 16'hxxxx;
   endfunction

   initial begin
      int v0, f0, o0, nbad, h;
      logic [WB-1:0]   b, lo;
      logic            g;
      logic [WB-1:0]   rb[$];
      logic            rg[$];
      logic [2*WB-1:0] exp_q[$];
      cyc(3);
      chk("rst_word", o_word, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_ferr", o_frame_err, 0);
      chk("rst_ovr", o_overrun, 0);
      rst = 1'b1;
      cyc(3);
      chk("idle_valid", o_valid, 0);
      // reset mid-frame with a held word and a pending half-word
      send_word(16'h8899);
      cyc(2);
      chk("held_valid", o_valid, 1);
      chk("held_word", o_word, 16'h8899);
      send_byte(8'h77);
      cyc(3);
      send_byte(8'h3C, 1'b1, 4);
      i_rx = 1'b1 & 8'h3C >> 3;
      cyc(2);
      rst = 1'b0;
      cyc(1);
      chk("midrst_valid", o_valid, 0);
      chk("midrst_word", o_word, 0);
      i_rx = 1'b1;
      cyc(2);
      rst = 1'b1;
      cyc(3);
      chk("post_word", o_word, 0);
      chk("post_valid", o_valid, 0);
      chk("post_pulses", {o_frame_err, o_overrun}, 0);
      i_ready = 1'b1;
      acc.delete();
      send_word(16'hBBAA);
      cyc(3);
      chk("after_rst_n", acc.size(), 1);
      chk("after_rst_w", acc_at(0), 16'hBBAA);
      // plain word with the consumer ready
      acc.delete();
      v0 = vld_cnt; f0 = fe_cnt; o0 = ov_cnt;
      send_word(16'h1234);
      cyc(4);
      chk("ready_vcycles", vld_cnt - v0, 1);
      chk("ready_word", acc_at(0), 16'h1234);
      chk("ready_ferr", fe_cnt - f0, 0);
      chk("ready_ovr", ov_cnt - o0, 0);
      chk("ready_valid", o_valid, 0);
      // half-bit glitch on an idle line
      acc.delete();
      f0 = fe_cnt;
      i_rx = 1'b0;
      cyc(CPB / 2);
      i_rx = 1'b1;
      cyc(8);
      send_word(16'h8001);
      cyc(3);
      chk("glitch_ferr", fe_cnt - f0, 0);
      chk("glitch_n", acc.size(), 1);
      chk("glitch_word", acc_at(0), 16'h8001);
      // framing error discards the pending half-word
      acc.delete();
      f0 = fe_cnt;
      send_byte(8'h55, 1'b0);
      cyc(2 * CPB);
      send_word(16'h2211);
      cyc(3);
      chk("ferr_pulses", fe_cnt - f0, 1);
      chk("ferr_n", acc.size(), 1);
      chk("ferr_word", acc_at(0), 16'h2211);
      // backpressure and overrun
      i_ready = 1'b0;
      acc.delete();
      o0 = ov_cnt;
      send_word(16'hA1B2);
      cyc(3);
      chk("bp_valid", o_valid, 1);
      chk("bp_word1", o_word, 16'hA1B2);
      send_word(16'hC3D4);
      cyc(3);
      chk("bp_word2", o_word, 16'hA1B2);
      chk("bp_ovr", ov_cnt - o0, 1);
      i_ready = 1'b1;
      cyc(1);
      i_ready = 1'b0;
      chk("bp_drop", o_valid, 0);
      chk("bp_acc", acc_at(0), 16'hA1B2);
      // accept and load on the same edge: the second byte's stop sample lands one edge after send returns
      acc.delete();
      o0 = ov_cnt;
      send_word(16'h1357);
      cyc(3);
      chk("co_held", o_word, 16'h1357);
      send_byte(8'h68);
      cyc(2);
      send_byte(8'h24);
      i_ready = 1'b1;
      cyc(1);
      i_ready = 1'b0;
      chk("co_valid", o_valid, 1);
      chk("co_word", o_word, 16'h2468);
      chk("co_ovr", ov_cnt - o0, 0);
      chk("co_acc", acc_at(0), 16'h1357);
      i_ready = 1'b1;
      cyc(2);
      chk("co_drain", o_valid, 0);
      // random bytes, some with a low stop bit, against the byte-level pairing rules
      acc.delete();
      f0 = fe_cnt;
      nbad = 0;
      for (int i = 0; i < 16; i++) begin
         b = 8'($urandom);
         g = $urandom_range(0, 4) != 0;
         rb.push_back(b);
         rg.push_back(g);
         send_byte(b, g);
         cyc(g ? int'($urandom_range(1, 6)) : 2 * CPB);
      end
      h = 0;
      lo = '0;
      foreach (rb[i]) begin
         if (!rg[i]) begin
            nbad++;
            h = 0;
         end else if (h == 0) begin
            lo = rb[i];
            h = 1;
         end else begin
            exp_q.push_back({rb[i], lo});
            h = 0;
         end
      end
      cyc(3);
      chk("rnd_ferr", fe_cnt - f0, nbad);
      chk("rnd_n", acc.size(), exp_q.size());
      foreach (exp_q[i]) chk($sformatf("rnd_word%0d", i), acc_at(i), exp_q[i]);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
